// File: rtl/opensync_fcs_pkg.sv
// Shared constants and types for the opensync transmit-path FCS regeneration stage.
package opensync_fcs_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        CLS_PRE  = 2'd0,
        CLS_DATA = 2'd1,
        CLS_FCS  = 2'd2
    } byte_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_BODY = 2'd2,
        ST_TAIL = 2'd3
    } fcs_state_e;

    // Per-stage tag travelling with each byte through the delay line
    typedef struct packed {
        logic       is_first;
        logic       is_pre;
        logic       is_long;
        logic       en;
        logic [7:0] data;
    } stage_t;

endpackage

// File: rtl/opensync_fcs_regenerate_crc32_d8_update.sv
// Combinational reflected CRC-32 update by one byte (LSB-first, Ethernet polynomial).
module crc32_d8_update
    import opensync_fcs_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next_c
);

    always_comb begin
        crc_next_c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next_c = crc_next_c[0] ? ((crc_next_c >> 1) ^ CRC32_POLY_REFL)
                                       : (crc_next_c >> 1);
        end
    end

endmodule

// File: rtl/opensync_fcs_regenerate.sv
// Recomputes Ethernet FCS over frames leaving the correction-field stage and
// substitutes it for the stale trailing FCS; fixed 4-cycle latency, no back-pressure.
module opensync_fcs_regenerate
    import opensync_fcs_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 8,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       iv_data,
    input  logic             i_data_wr,
    input  logic             i_fcs_recalc_en,
    output logic [7:0]       ov_data,
    output logic             o_data_wr,
    output logic             o_fcs_replaced,
    output logic             o_runt,
    output logic [CNT_W-1:0] ov_frame_cnt,
    output logic [CNT_W-1:0] ov_replace_cnt
);

    localparam int unsigned MIN_LEN = PREAMBLE_BYTES + 5;
    localparam int unsigned POS_W   = $clog2(MIN_LEN + 1);
    localparam int unsigned DEPTH   = 4;

    fcs_state_e       state, state_nxt;
    logic [POS_W-1:0] cnt, cnt_nxt, pos_c;
    logic [2:0]       tail_cnt, tail_cnt_nxt;
    logic             en_lat, en_lat_nxt;
    logic             armed;
    logic             start_c, take_c;

    stage_t           stg [1:DEPTH];
    logic [DEPTH:1]   vld;
    stage_t           in_stg_c;

    logic [31:0]      crc, crc_base_c, crc_upd_c;
    logic [2:0]       run_c;
    byte_class_e      cls_c;
    logic             frame_long_c, sub_c, last_in_s3_c;
    logic [7:0]       sub_byte_c;

    // Input-side frame tracking: byte position, latched enable, drop-after-reset guard
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        tail_cnt_nxt = tail_cnt;
        en_lat_nxt   = en_lat;
        start_c      = 1'b0;
        take_c       = 1'b0;
        pos_c        = cnt;
        case (state)
            ST_IDLE, ST_TAIL: begin
                if (state == ST_TAIL) begin
                    tail_cnt_nxt = tail_cnt + 3'd1;
                    if (tail_cnt == 3'd3) state_nxt = ST_IDLE;
                end
                if (i_data_wr && armed) begin
                    start_c    = 1'b1;
                    take_c     = 1'b1;
                    pos_c      = POS_W'(1);
                    cnt_nxt    = POS_W'(1);
                    en_lat_nxt = i_fcs_recalc_en;
                    state_nxt  = (PREAMBLE_BYTES <= 1) ? ST_BODY : ST_PRE;
                end
            end
            ST_PRE, ST_BODY: begin
                if (i_data_wr) begin
                    take_c  = 1'b1;
                    pos_c   = (cnt == POS_W'(MIN_LEN)) ? cnt : cnt + POS_W'(1);
                    cnt_nxt = pos_c;
                    if (state == ST_PRE && pos_c >= POS_W'(PREAMBLE_BYTES)) state_nxt = ST_BODY;
                end else begin
                    state_nxt    = ST_TAIL;
                    tail_cnt_nxt = 3'd0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tail_cnt <= '0;
            en_lat   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tail_cnt <= tail_cnt_nxt;
            en_lat   <= en_lat_nxt;
            armed    <= armed | ~i_data_wr;
        end
    end

    always_comb begin
        in_stg_c = '0;
        if (take_c) begin
            in_stg_c.is_first = start_c;
            in_stg_c.is_pre   = (pos_c <= POS_W'(PREAMBLE_BYTES));
            in_stg_c.is_long  = (pos_c >= POS_W'(MIN_LEN));
            in_stg_c.en       = start_c ? i_fcs_recalc_en : en_lat;
            in_stg_c.data     = iv_data;
        end
    end

    // Bytes still following the exiting byte in its frame; fewer than 4 means it is FCS
    always_comb begin
        run_c = 3'd0;
        if (vld[3]) begin
            run_c = 3'd1;
            if (vld[2]) begin
                run_c = 3'd2;
                if (vld[1]) begin
                    run_c = 3'd3;
                    if (take_c) run_c = 3'd4;
                end
            end
        end
    end

    always_comb begin
        cls_c = (run_c == 3'd4) ? (stg[DEPTH].is_pre ? CLS_PRE : CLS_DATA) : CLS_FCS;
        case (run_c)
            3'd0:    frame_long_c = stg[4].is_long;
            3'd1:    frame_long_c = stg[3].is_long;
            3'd2:    frame_long_c = stg[2].is_long;
            default: frame_long_c = stg[1].is_long;
        endcase
        case (run_c)
            3'd3:    sub_byte_c = ~crc[7:0];
            3'd2:    sub_byte_c = ~crc[15:8];
            3'd1:    sub_byte_c = ~crc[23:16];
            default: sub_byte_c = ~crc[31:24];
        endcase
        sub_c        = vld[DEPTH] && (cls_c == CLS_FCS) && stg[DEPTH].en && frame_long_c;
        crc_base_c   = stg[DEPTH].is_first ? CRC32_INIT : crc;
        last_in_s3_c = vld[3] && !vld[2];
    end

    crc32_d8_update u_crc (
        .crc        (crc_base_c),
        .data       (stg[DEPTH].data),
        .crc_next_c (crc_upd_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 1; i <= DEPTH; i++) stg[i] <= '0;
            vld            <= '0;
            crc            <= CRC32_INIT;
            o_fcs_replaced <= 1'b0;
            o_runt         <= 1'b0;
            ov_frame_cnt   <= '0;
            ov_replace_cnt <= '0;
        end else begin
            stg[1] <= in_stg_c;
            for (int i = 2; i <= DEPTH; i++) stg[i] <= stg[i-1];
            vld <= {vld[DEPTH-1:1], take_c};
            if (vld[DEPTH] && cls_c == CLS_DATA) crc <= crc_upd_c;
            else if (vld[DEPTH] && stg[DEPTH].is_first) crc <= CRC32_INIT;
            // Pulses are aligned to the frame's last byte as it moves into stage 4
            o_fcs_replaced <= last_in_s3_c && stg[3].is_long && stg[3].en;
            o_runt         <= last_in_s3_c && !stg[3].is_long;
            if (start_c) ov_frame_cnt <= ov_frame_cnt + CNT_W'(1);
            if (last_in_s3_c && stg[3].is_long && stg[3].en) ov_replace_cnt <= ov_replace_cnt + CNT_W'(1);
        end
    end

    // The first FCS byte exits in the gap cycle itself, so the substitution mux sits after stage 4
    assign o_data_wr = vld[DEPTH];
    assign ov_data   = sub_c ? sub_byte_c : stg[DEPTH].data;

endmodule

// File: tb/tb_opensync_fcs_regenerate.sv
// Randomised and directed bench for opensync_fcs_regenerate against a frame-level reference model.
module tb_opensync_fcs_regenerate;

    localparam int PRE   = 8;
    localparam int MINL  = PRE + 5;
    localparam int MAXC  = 1024;
    localparam int TAILC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_wr, i_en;
    logic [7:0]  ov_data, w_data;
    logic        o_wr, o_rep, o_runt, w_wr, w_rep, w_runt;
    logic [15:0] o_fc, o_rc;
    logic [1:0]  w_fc, w_rc;

    always #4 clk = ~clk;

    opensync_fcs_regenerate #(.PREAMBLE_BYTES(PRE), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .iv_data(i_data), .i_data_wr(i_wr), .i_fcs_recalc_en(i_en),
        .ov_data(ov_data), .o_data_wr(o_wr), .o_fcs_replaced(o_rep), .o_runt(o_runt),
        .ov_frame_cnt(o_fc), .ov_replace_cnt(o_rc));

    // Narrow-counter instance shares the stimulus so counter wrap is reached quickly
    opensync_fcs_regenerate #(.PREAMBLE_BYTES(PRE), .CNT_W(2)) dut_w (
        .i_clk(clk), .i_rst(rst), .iv_data(i_data), .i_data_wr(i_wr), .i_fcs_recalc_en(i_en),
        .ov_data(w_data), .o_data_wr(w_wr), .o_fcs_replaced(w_rep), .o_runt(w_runt),
        .ov_frame_cnt(w_fc), .ov_replace_cnt(w_rc));

    int n_cmp = 0, n_bad = 0;
    int m_frames = 0, m_reps = 0;
    int n_cyc;

    logic [7:0]  fr [$];
    logic        s_wr [MAXC];
    logic [7:0]  s_d  [MAXC];
    logic        s_en [MAXC];
    logic        e_wr [MAXC];
    logic [7:0]  e_d  [MAXC];
    logic        e_rep [MAXC], e_runt [MAXC], e_fs [MAXC], e_rs [MAXC];
    logic [46:0] cap   [MAXC];
    logic [46:0] exp_v [MAXC];

    function automatic logic [46:0] observe();
        return {o_wr, o_wr ? ov_data : 8'h00, o_rep, o_runt, o_fc, o_rc, w_fc, w_rc};
    endfunction

    // Standard CRC-32 of fr[lo..hi], computed MSB-first on the unreflected polynomial
    function automatic logic [31:0] ref_crc(input int lo, input int hi);
        logic [31:0] c, r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = lo; i <= hi; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ fr[i][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        c = ~c;
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return r;
    endfunction

    task automatic load_vector();
        fr.delete();
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
    endtask

    task automatic clear_stream();
        n_cyc = 0;
        for (int i = 0; i < MAXC; i++) begin
            s_wr[i] = 1'b0; s_d[i] = 8'h00; s_en[i] = 1'b0;
            e_wr[i] = 1'b0; e_d[i] = 8'h00; e_rep[i] = 1'b0; e_runt[i] = 1'b0;
            e_fs[i] = 1'b0; e_rs[i] = 1'b0;
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_wr[n_cyc] = 1'b0;
            s_d[n_cyc]  = 8'($urandom);
            s_en[n_cyc] = 1'($urandom);
            n_cyc++;
        end
    endtask

    // Appends fr as one frame (plus the mandatory gap) and records its expected output
    task automatic add_frame(input logic en);
        int          len, s;
        logic        long_f, rep;
        logic [31:0] c;
        len    = fr.size();
        s      = n_cyc;
        long_f = (len >= MINL);
        rep    = en && long_f;
        c      = long_f ? ref_crc(PRE, len - 5) : 32'h0;
        for (int k = 0; k < len; k++) begin
            s_wr[s+k]  = 1'b1;
            s_d[s+k]   = fr[k];
            s_en[s+k]  = (k == 0) ? en : 1'($urandom);
            e_wr[s+k+4] = 1'b1;
            e_d[s+k+4]  = (rep && k >= len - 4) ? c[8*(k-(len-4)) +: 8] : fr[k];
        end
        e_fs[s+1]       = 1'b1;
        e_rs[s+len+3]   = rep;
        e_rep[s+len+3]  = rep;
        e_runt[s+len+3] = !long_f;
        n_cyc += len;
        add_idle(1);
    endtask

    task automatic build_expected();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            m_frames += int'(e_fs[i]);
            m_reps   += int'(e_rs[i]);
            exp_v[i] = {e_wr[i], e_wr[i] ? e_d[i] : 8'h00, e_rep[i], e_runt[i],
                        16'(m_frames), 16'(m_reps), 2'(m_frames), 2'(m_reps)};
        end
    endtask

    task automatic run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            @(negedge clk);
            i_wr   = (i < n_cyc) ? s_wr[i] : 1'b0;
            i_data = (i < n_cyc) ? s_d[i]  : 8'h00;
            i_en   = (i < n_cyc) ? s_en[i] : 1'b0;
            #1;
            cap[i] = observe();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_wr = 1'b0; i_data = 8'h00; i_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (observe() !== 47'd0) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", observe(), 47'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (observe() !== 47'd0) begin
            n_bad++; $display("FAIL idle_after_reset: got %h want %h", observe(), 47'd0);
        end
    endtask

    task automatic test_replace();
        logic [31:0] kfcs;
        kfcs = 32'hCBF4_3926;
        clear_stream(); add_idle(1); load_vector(); add_frame(1'b1); add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL replace cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cap[22+j][45:38] !== kfcs[8*j +: 8] || cap[22+j][46] !== 1'b1) begin
                n_bad++; $display("FAIL known_fcs byte %0d: got %h want %h", j, cap[22+j][45:38], kfcs[8*j +: 8]);
            end
        end
        n_cmp++;
        if (cap[25][37] !== 1'b1 || cap[25][19:4] !== 16'd1) begin
            n_bad++; $display("FAIL known_pulse: got rep=%b cnt=%h want rep=1 cnt=0001", cap[25][37], cap[25][19:4]);
        end
    endtask

    task automatic test_passthrough();
        clear_stream(); load_vector(); add_frame(1'b0); add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL passthrough cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stream();
        load_vector(); add_frame(1'b1);
        load_vector(); add_frame(1'b0);
        load_vector(); fr[10] = 8'hA5; add_frame(1'b1);
        add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL back_to_back cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_runt();
        int lens [4] = '{11, 12, 13, 1};
        clear_stream(); add_idle(1);
        for (int f = 0; f < 4; f++) begin
            fr.delete();
            for (int k = 0; k < lens[f]; k++) fr.push_back(8'($urandom));
            add_frame(1'b1);
        end
        add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL runt cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
        n_cmp++;
        if (cap[15][36] !== 1'b1 || cap[15][37] !== 1'b0) begin
            n_bad++; $display("FAIL runt_pulse: got runt=%b rep=%b want runt=1 rep=0", cap[15][36], cap[15][37]);
        end
    endtask

    task automatic test_random();
        int len;
        clear_stream(); add_idle(1);
        for (int f = 0; f < 10; f++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MINL - 1) : $urandom_range(MINL, 40);
            fr.delete();
            for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
            add_frame(1'($urandom));
            add_idle($urandom_range(0, 2));
        end
        add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL random cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        load_vector();
        for (int k = 0; k < fr.size(); k++) begin
            @(negedge clk);
            i_wr = 1'b1; i_data = fr[k]; i_en = 1'b1;
            if (k == 9) begin
                #1 rst = 1'b1;
                #1;
                n_cmp++;
                if ({o_wr, o_rep, o_runt, o_fc, o_rc} !== 35'd0) begin
                    n_bad++; $display("FAIL reset_async: got wr=%b fc=%h rc=%h want all 0", o_wr, o_fc, o_rc);
                end
            end
            if (k == 13) rst = 1'b0;
            if (k > 9) begin
                #1;
                n_cmp++;
                if (o_wr !== 1'b0) begin
                    n_bad++; $display("FAIL reset_drop byte %0d: got wr=%b want 0", k, o_wr);
                end
            end
        end
        m_frames = 0; m_reps = 0;
        clear_stream(); add_idle(2); load_vector(); add_frame(1'b1); add_idle(2);
        build_expected(); run_stream();
        for (int i = 0; i < n_cyc + TAILC; i++) begin
            n_cmp++;
            if (cap[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL reset_recover cyc %0d: got %h want %h", i, cap[i], exp_v[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_replace();
        test_passthrough();
        test_back_to_back();
        test_runt();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
